// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks a 10-bit byte pc and keeps one memory read outstanding.
// Returned words go into a 2-entry queue for decode; a branch redirect flushes the queue and discards any read still in flight.
module fetch_unit #(
  parameter logic [9:0] RESET_PC = 10'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic [9:0]  targetAddress,
  output logic        imem_req,
  output logic [9:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [9:0]  if_pc,
  input  logic        if_ready
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t      r_state;
  logic [9:0]  r_pc;
  logic        r_req;
  logic [9:0]  r_addr;
  logic [1:0]  r_count;
  logic        r_head;
  logic [31:0] r_fifo_instr [2];
  logic [9:0]  r_fifo_pc    [2];

  state_t      w_state_nxt;
  logic [9:0]  w_pc_nxt;
  logic        w_req_nxt;
  logic [9:0]  w_addr_nxt;
  logic        w_push;
  logic        w_flush;
  logic        w_pop;
  logic        w_tail;
  logic [1:0]  w_count_post;
  logic [9:0]  w_target;
  logic [9:0]  w_addr_inc;

  assign w_target     = {targetAddress[9:2], 2'b00};
  assign w_addr_inc   = r_addr + 10'd4;  // wraps modulo 1024
  assign w_pop        = if_valid && if_ready && !branch;
  assign w_tail       = r_head ^ r_count[0];
  assign w_count_post = r_count + 2'd1 - {1'b0, w_pop};

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (branch) begin
          w_flush   = 1'b1;
          w_pc_nxt  = w_target;
          w_req_nxt = 1'b0;
        end else if (r_count <= 2'd1) begin
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_pc;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (branch) begin
          w_flush  = 1'b1;
          w_pc_nxt = w_target;
          if (imem_ack) begin
            w_req_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DROP;  // keep the old request up until memory answers it
          end
        end else if (imem_ack) begin
          w_push   = 1'b1;
          w_pc_nxt = w_addr_inc;
          if (w_count_post <= 2'd1) begin
            w_addr_nxt = w_addr_inc;
          end else begin
            w_req_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (branch) begin
          w_flush  = 1'b1;
          w_pc_nxt = w_target;
        end
        if (imem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_count <= 2'd0;
      r_head  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      if (w_flush) begin
        r_count <= 2'd0;
        r_head  <= 1'b0;
      end else begin
        if (w_push && !w_pop)      r_count <= r_count + 2'd1;
        else if (!w_push && w_pop) r_count <= r_count - 2'd1;
        if (w_pop) r_head <= ~r_head;
      end
    end
  end

  // NOTE: queue storage has no reset; its outputs are masked to zero while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[w_tail] <= imem_rdata;
      r_fifo_pc[w_tail]    <= r_addr;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign if_valid  = (r_count != 2'd0);
  assign if_instr  = if_valid ? r_fifo_instr[r_head] : 32'd0;
  assign if_pc     = if_valid ? r_fifo_pc[r_head]    : 10'd0;

endmodule
